// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S audio paths.
package audio_pkg;

    localparam int MCLK_PER_FRAME = 256;
    localparam int MCLK_PER_BIT   = 4;
    localparam int SLOTS_PER_HALF = 32;

    typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/audio_if.sv
// Pocket audio bundle: clocks and data lines between core and codec.
interface audio_if;

    logic mclk;
    logic lrck;
    logic dac;
    logic adc;

    // Receive side owns the clocking and parks the DAC line.
    modport rx (
        output mclk,
        output lrck,
        output dac,
        input  adc
    );

endinterface

// File: rtl/audio_frame_timer.sv
// Frame timing shared by both audio directions: 8-bit frame counter,
// lrck, slot/phase decode and per-bit capture / end-of-half strobes.
module audio_frame_timer
    import audio_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic lrck,
    output logic capture,
    output logic left_done,
    output logic right_done
);

    // Counter value of the cycle in which the last data bit of the left half is taken.
    localparam logic [7:0] LAST_BIT_CNT = 8'(MCLK_PER_BIT * WIDTH + MCLK_PER_BIT - 1);
    localparam logic [7:0] HALF_CNT     = 8'(MCLK_PER_FRAME / 2);

    logic [7:0] count_reg;
    logic [4:0] slot;
    logic [1:0] phase;

    // Free-running frame counter, wraps naturally at 256.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign slot  = count_reg[6:2];
    assign phase = count_reg[1:0];

    // lrck is taken straight from the counter flop, so it is glitch-free.
    assign lrck = count_reg[7];

    // Capture on the last mclk of each data bit; slot 0 is the I2S delay bit.
    assign capture    = (phase == 2'(MCLK_PER_BIT - 1)) && (slot >= 5'd1) && (slot <= 5'(WIDTH));
    assign left_done  = (count_reg == LAST_BIT_CNT);
    assign right_done = (count_reg == HALF_CNT + LAST_BIT_CNT);

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S receiver: drives mclk/lrck, deserialises the ADC line into a
// stereo pair and pulses sound_valid once per frame.
module audio_i2s_receiver
    import audio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_12_288_mhz,
    input  logic                    reset_n,
    audio_if.rx                     audio,
    output logic signed [WIDTH-1:0] sound_l,
    output logic signed [WIDTH-1:0] sound_r,
    output logic                    sound_valid
);

    logic                   lrck;
    logic                   capture;
    logic                   left_done;
    logic                   right_done;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   adc_s;
    logic [WIDTH-1:0]       sr_reg;
    logic [WIDTH-1:0]       sr_next;
    logic [WIDTH-1:0]       left_reg;

    audio_frame_timer #(
        .WIDTH (WIDTH)
    ) u_timer (
        .clk        (clk_12_288_mhz),
        .rst_n      (reset_n),
        .lrck       (lrck),
        .capture    (capture),
        .left_done  (left_done),
        .right_done (right_done)
    );

    assign audio.mclk = clk_12_288_mhz;
    assign audio.lrck = lrck;
    assign audio.dac  = 1'b0;

    // ADC input synchroniser chain.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0] <= audio.adc;
        end
    end

    assign adc_s = sync_reg[SYNC_STAGES-1];

    // Shift value including the bit being captured this cycle; the holding
    // registers take it directly so the pair is complete when sound_valid rises.
    generate
        if (WIDTH > 1) begin : g_shift
            assign sr_next = {sr_reg[WIDTH-2:0], adc_s};
        end else begin : g_bit
            assign sr_next = adc_s;
        end
    endgenerate

    // MSB-first shift register, advanced once per data bit.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sr_reg <= '0;
        end else if (capture) begin
            sr_reg <= sr_next;
        end
    end

    // Park the completed left word until the right word finishes.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            left_reg <= '0;
        end else if (left_done) begin
            left_reg <= sr_next;
        end
    end

    // Publish both channels together with a one-cycle valid pulse.
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            sound_l     <= '0;
            sound_r     <= '0;
            sound_valid <= 1'b0;
        end else begin
            sound_valid <= right_done;
            if (right_done) begin
                sound_l <= left_reg;
                sound_r <= sr_next;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Self-checking bench for audio_i2s_receiver (WIDTH=16, SYNC_STAGES=2).
module tb_audio_i2s_receiver;
    import audio_pkg::*;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          mode;   // 0: zero filler, 1: one filler, 2: phase-3 pulses, 3: random filler
        sample_t     exp_l;
        sample_t     exp_r;
    } vec_t;

    logic    clk = 1'b0;
    logic    reset_n;
    sample_t sound_l;
    sample_t sound_r;
    logic    sound_valid;

    audio_if aif();

    audio_i2s_receiver #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk_12_288_mhz (clk),
        .reset_n        (reset_n),
        .audio          (aif),
        .sound_l        (sound_l),
        .sound_r        (sound_r),
        .sound_valid    (sound_valid)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        in_reset;
    logic [15:0] cur_l;
    logic [15:0] cur_r;
    int          cur_mode;
    sample_t     exp_l;
    sample_t     exp_r;
    sample_t     last_l;
    sample_t     last_r;
    vec_t        tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // I2S line level for frame position c, from the frame format rules.
    function automatic logic adc_level(input int c, input logic [15:0] l, input logic [15:0] r, input int mode);
        int          slot;
        int          phase;
        logic [15:0] s;
        slot  = (c % 128) / 4;
        phase = c % 4;
        s     = (c >= 128) ? r : l;
        if (mode == 2) return (slot >= 1 && slot <= 16 && phase == 3);
        if (slot >= 1 && slot <= 16) return s[16 - slot];
        if (mode == 1) return 1'b1;
        if (mode == 3) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic drive();
        if (in_reset) aif.adc = 1'($urandom_range(0, 1));
        else          aif.adc = adc_level(cyc % 256, cur_l, cur_r, cur_mode);
    endtask

    task automatic check_cycle();
        int c;
        c = cyc % 256;
        check("dac", 32'(aif.dac), 32'd0);
        check("mclk", 32'(aif.mclk), 32'(clk));
        if (in_reset) begin
            check("rst_lrck", 32'(aif.lrck), 32'd0);
            check("rst_valid", 32'(sound_valid), 32'd0);
            check("rst_sound_l", 32'(sound_l), 32'd0);
            check("rst_sound_r", 32'(sound_r), 32'd0);
        end else begin
            check("lrck", 32'(aif.lrck), 32'(c >= 128));
            check("valid", 32'(sound_valid), 32'(c == 196));
            if (c == 196) begin
                last_l = exp_l;
                last_r = exp_r;
                check("sound_l", 32'(sound_l), 32'(exp_l));
                check("sound_r", 32'(sound_r), 32'(exp_r));
                $display("pulse cyc=%0d sound_l=%0d sound_r=%0d expect_l=%0d expect_r=%0d",
                         cyc, sound_l, sound_r, exp_l, exp_r);
            end else begin
                check("hold_l", 32'(sound_l), 32'(last_l));
                check("hold_r", 32'(sound_r), 32'(last_r));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_frame(input logic [15:0] l, input logic [15:0] r, input int mode,
                             input sample_t el, input sample_t er);
        cur_l    = l;
        cur_r    = r;
        cur_mode = mode;
        exp_l    = el;
        exp_r    = er;
    endtask

    // Release just after an edge so that cycle 0 runs with the counter at 0.
    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_reset = 1'b0;
        cyc      = 0;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        logic [15:0] rl;
        logic [15:0] rr;

        tbl[0] = '{l: 16'h8001, r: 16'h7FFE, mode: 0, exp_l: -16'sd32767, exp_r: 16'sd32766};
        tbl[1] = '{l: 16'h8001, r: 16'h7FFE, mode: 1, exp_l: -16'sd32767, exp_r: 16'sd32766};
        tbl[2] = '{l: 16'hFFFF, r: 16'hFFFF, mode: 2, exp_l: 16'sd0,      exp_r: 16'sd0};
        for (int i = 3; i < 6; i++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            tbl[i] = '{l: rl, r: rr, mode: 3, exp_l: sample_t'(rl), exp_r: sample_t'(rr)};
        end

        // Reset held for 10 cycles with a noisy ADC line.
        reset_n  = 1'b0;
        in_reset = 1'b1;
        aif.adc  = 1'b0;
        last_l   = '0;
        last_r   = '0;
        set_frame(16'h0, 16'h0, 0, 16'sd0, 16'sd0);
        run(10);

        // Table frames: first starts at release.
        set_frame(tbl[0].l, tbl[0].r, tbl[0].mode, tbl[0].exp_l, tbl[0].exp_r);
        release_reset();
        run(255);
        for (int i = 1; i < 6; i++) begin
            set_frame(tbl[i].l, tbl[i].r, tbl[i].mode, tbl[i].exp_l, tbl[i].exp_r);
            run(256);
        end

        // Reset mid-frame at counter 100, after the left word is complete.
        set_frame(16'h5A5A, 16'hA5A5, 0, 16'sh5A5A, 16'shA5A5);
        run(101);
        check("pre_reset_pos", 32'(cyc % 256), 32'd100);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        in_reset = 1'b1;
        last_l   = '0;
        last_r   = '0;
        #1;
        check_cycle();
        drive();
        @(negedge clk);
        check_cycle();
        run(4);
        set_frame(16'h0F0F, 16'h00F0, 0, 16'sh0F0F, 16'sh00F0);
        release_reset();
        run(255);

        // Ten free-running frames with fixed samples.
        set_frame(16'h1234, 16'hEDCC, 0, 16'sd4660, -16'sd4660);
        run(2560);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
